// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared SPI definitions (FSM states, word-width and idle-word
//             defaults) used by both the SPI slave and the SPI master.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Transfer FSM: waiting for select, or shifting words while selected
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  // Bits per SPI word unless overridden
  localparam int DEFAULT_DATA_W = 8;

  // Fill bit of the word sent when nothing is queued (all-ones word)
  localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync
//  Brief    : WIDTH-bit, two-stage synchroniser for asynchronous inputs with
//             a per-bit reset value (synchronous, active-low reset).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two flops in series; the first may go metastable, the second settles it
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : spi_sync
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Brief    : SPI mode-0, MSB-first slave, oversampled by clk (SCK <= clk/8).
//             Single-entry TX holding register with valid/ready load, RX word
//             output with a one-cycle valid pulse, back-to-back words.
//             Optional feature macro: SPI_SLAVE_OVERRUN_EN adds rx_ack input
//             and sticky rx_overrun output.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{DEFAULT_IDLE_BIT}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              rx_ack,
  output logic              rx_overrun
`endif
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronised SPI pins: {ss_n, sck, mosi}, resetting to deselected/idle
  logic [2:0] sync_q;
  logic       ss_s, sck_s, mosi_s;

  spi_sync #(
    .WIDTH     (3),
    .RESET_VAL (3'b100)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ss_n, sck, mosi}),
    .q   (sync_q)
  );

  assign {ss_s, sck_s, mosi_s} = sync_q;

  logic             ss_prev;
  logic             sck_prev;
  logic [1:0]       settle;
  spi_state_t       state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             reload_pend;
  logic             hold_full;
  logic [DATA_W-1:0] hold_reg;

  // Previous synchronised samples for edge detection, plus a settle counter
  // so that a select already held low across reset is not taken as a fall
  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_prev  <= 1'b1;
      sck_prev <= 1'b0;
      settle   <= 2'd0;
    end else begin
      ss_prev  <= ss_s;
      sck_prev <= sck_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  logic ss_fall, ss_rise, sck_rise, sck_fall;
  assign ss_fall  = (settle == 2'd3) && ss_prev && !ss_s;
  assign ss_rise  = ss_s && !ss_prev;
  assign sck_rise = sck_s && !sck_prev;
  assign sck_fall = !sck_s && sck_prev;

  logic              word_done;
  logic              load_now;
  logic [DATA_W-1:0] load_word;
  assign word_done = (state == ST_SHIFT) && !ss_rise && sck_rise && (bit_cnt == LAST_BIT);
  assign load_now  = ((state == ST_IDLE) && ss_fall) ||
                     ((state == ST_SHIFT) && !ss_rise && sck_fall && reload_pend);
  assign load_word = hold_full ? hold_reg : IDLE_WORD;
  assign tx_ready  = !hold_full;

  // TX holding register: a new handshake wins over a simultaneous load,
  // since a load in that cycle necessarily took the idle word
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_reg  <= tx_data;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

  // Transfer FSM with registered miso/miso_oe/rx outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso        <= 1'b0;
          miso_oe     <= 1'b0;
          bit_cnt     <= '0;
          reload_pend <= 1'b0;
          if (ss_fall) begin
            state     <= ST_SHIFT;
            shift_reg <= load_word;
            miso      <= load_word[DATA_W-1];
            miso_oe   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            // Deselect discards any partial word
            state       <= ST_IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[DATA_W-2:0], mosi_s};
            if (word_done) begin
              rx_data     <= {shift_reg[DATA_W-2:0], mosi_s};
              rx_valid    <= 1'b1;
              bit_cnt     <= '0;
              reload_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (reload_pend) begin
              shift_reg   <= load_word;
              miso        <= load_word[DATA_W-1];
              reload_pend <= 1'b0;
            end else begin
              miso <= shift_reg[DATA_W-1];
            end
          end
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pending;

  // Sticky overrun: a word completed while the previous one is still unacked
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_pending <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (word_done) begin
      rx_pending <= 1'b1;
      if (rx_pending && !rx_ack) rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      rx_pending <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Brief    : Self-checking bench for spi_slave. A bit-banged mode-0 master
//             at clk/10; received RX words are checked by a scoreboard
//             monitor, MISO words are checked by the master. Exercises the
//             SPI_SLAVE_OVERRUN_EN feature when that macro is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
`endif

  always #10 clk = ~clk;

  spi_slave #(
    .DATA_W    (8),
    .IDLE_WORD (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_rx_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the next queued word
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: rx_valid with rx_data 0x%0h, required no pulse", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input logic [7:0] d);
    check("tx_ready_before_load", 8'(tx_ready), 8'h01);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_load", 8'(tx_ready), 8'h00);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic ss_high();
    wait_clks(4);
    ss_n = 1'b1;
    wait_clks(8);
  endtask

  // Mode 0: mosi changes while sck is low, miso is sampled at the rising edge
  task automatic spi_bits(input logic [7:0] out, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = out[7-i];
      wait_clks(HALF);
      sck = 1'b1;
      got = {got[6:0], miso};
      wait_clks(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [7:0] out, input logic [7:0] exp_miso, input string name);
    logic [7:0] got;
    exp_rx_q.push_back(out);
    spi_bits(out, 8, got);
    check(name, got, exp_miso);
  endtask

`ifdef SPI_SLAVE_OVERRUN_EN
  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    logic [7:0] partial;

    // Reset state
    wait_clks(4);
    check("reset_miso", 8'(miso), 8'h00);
    check("reset_miso_oe", 8'(miso_oe), 8'h00);
    check("reset_tx_ready", 8'(tx_ready), 8'h01);
    check("reset_rx_valid", 8'(rx_valid), 8'h00);
    check("reset_rx_data", rx_data, 8'h00);
    rst = 1'b1;
    wait_clks(4);

    // Single word with a TX word loaded
    tx_load(8'hA5);
    ss_low();
    check("miso_oe_selected", 8'(miso_oe), 8'h01);
    check("tx_ready_after_entry", 8'(tx_ready), 8'h01);
    spi_word(8'h3C, 8'hA5, "miso_single");
    ss_high();
    check("idle_miso", 8'(miso), 8'h00);
    check("idle_miso_oe", 8'(miso_oe), 8'h00);

    // Nothing loaded: idle word goes out
    ss_low();
    spi_word(8'h00, 8'hFF, "miso_idle_word");
    ss_high();
    check("tx_ready_stays_high", 8'(tx_ready), 8'h01);

    // Back-to-back words, second TX word loaded during the first
    tx_load(8'h11);
    fork
      begin
        ss_low();
        spi_word(8'h81, 8'h11, "miso_b2b_w1");
        spi_word(8'h42, 8'h22, "miso_b2b_w2");
        ss_high();
      end
      begin
        wait_clks(38);
        tx_load(8'h22);
      end
    join

    // Abort after 5 bits, then a full transfer
    ss_low();
    spi_bits(8'hFF, 5, partial);
    check("miso_abort_partial", partial, 8'h1F);
    ss_high();
    wait_clks(10);
    check("abort_rx_data_kept", rx_data, 8'h42);
    check("abort_idle_miso_oe", 8'(miso_oe), 8'h00);
    tx_load(8'h96);
    ss_low();
    spi_word(8'h5A, 8'h96, "miso_after_abort");
    ss_high();

    // Reset for one clk after bit 3, with a TX word pending
    ss_low();
    spi_bits(8'hF0, 3, partial);
    tx_load(8'h77);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_miso", 8'(miso), 8'h00);
    check("rstmid_miso_oe", 8'(miso_oe), 8'h00);
    check("rstmid_tx_ready", 8'(tx_ready), 8'h01);
    check("rstmid_rx_valid", 8'(rx_valid), 8'h00);
    check("rstmid_rx_data", rx_data, 8'h00);
    rst = 1'b1;
    wait_clks(10);
    check("rstmid_no_restart_oe", 8'(miso_oe), 8'h00);
    ss_high();
    ss_low();
    spi_word(8'hC3, 8'hFF, "miso_after_reset_idle");
    ss_high();
    tx_load(8'h3C);
    ss_low();
    spi_word(8'hE7, 8'h3C, "miso_after_reset_load");
    ss_high();

`ifdef SPI_SLAVE_OVERRUN_EN
    ack_pulse();
    check("overrun_cleared_start", 8'(rx_overrun), 8'h00);
    ss_low();
    spi_word(8'h12, 8'hFF, "miso_ovr_w1");
    ss_high();
    check("overrun_after_first", 8'(rx_overrun), 8'h00);
    ss_low();
    spi_word(8'h34, 8'hFF, "miso_ovr_w2");
    ss_high();
    check("overrun_after_second", 8'(rx_overrun), 8'h01);
    ack_pulse();
    check("overrun_after_ack", 8'(rx_overrun), 8'h00);
`endif

    wait_clks(20);
    check("rx_queue_drained", 8'(exp_rx_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spi_slave
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning bits per SPI word.
REQ-002 SHALL provide parameter IDLE_WORD, default all-ones, meaning the word shifted out on MISO when no TX word is loaded.
REQ-003 SHALL provide port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL provide port sck  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL provide port ss_n  input  1  slave select, active-low, asynchronous.
REQ-007 SHALL provide port mosi  input  1  serial data from master, asynchronous.
REQ-008 SHALL provide port miso  output  1  serial data to master.
REQ-009 SHALL provide port miso_oe  output  1  MISO drive enable; high only while selected.
REQ-010 SHALL provide port tx_data  input  DATA_W  word to send in the next transfer.
REQ-011 SHALL provide port tx_valid / tx_ready  input / output  1 each  TX load handshake.
REQ-012 SHALL provide port rx_data  output  DATA_W  last completely received word.
REQ-013 SHALL provide port rx_valid  output  1  one-clk pulse when rx_data updates.

Function
REQ-014 SHALL pass sck, ss_n and mosi through 2-flop synchronisers before use; sck edges come from synchronised-sample comparison.
REQ-015 SHALL support SPI mode 0 only (CPOL=0, CPHA=0), MSB first; the master's SCK SHALL be at most clk/8.
REQ-016 SHALL implement FSM IDLE -> SHIFT on synchronised ss_n fall; SHIFT -> IDLE on synchronised ss_n rise; no other states.
REQ-017 On entry to SHIFT: load shift register from the TX holding register if full, else from IDLE_WORD; clear bit counter; drive MSB on miso.
REQ-018 SHALL sample mosi into the shift LSB on each sck rise and present the next TX bit on miso on each sck fall.
REQ-019 On the DATA_W-th sck rise: copy the shift register to rx_data; pulse rx_valid on the next clk cycle; clear the bit counter; reload TX at the following sck fall. Back-to-back words without ss_n rise SHALL be supported.
REQ-020 ss_n rise mid-word SHALL discard the partial word: no rx_valid, rx_data unchanged, bit counter cleared.
REQ-021 tx_ready SHALL be high when the single-entry TX holding register is empty; a transfer occurs on a clk cycle with tx_valid and tx_ready both high.
REQ-022 The holding register SHALL empty when its word is loaded into the shift register; a handshake in the same cycle as that load SHALL be held for the next word.
REQ-023 miso SHALL be 0 and miso_oe 0 while in IDLE.

Reset
REQ-024 With rst low at a clk edge: FSM=IDLE, counters cleared, holding register empty, rx_data=0, rx_valid=0, tx_ready=1, miso=0, miso_oe=0; synchroniser flops reset to ss_n=1, sck=0, mosi=0.
REQ-025 Reset during SHIFT SHALL abort the word with no rx_valid; after release, a new transfer SHALL start only on a fresh ss_n fall.

Configuration
REQ-026 With macro SPI_SLAVE_OVERRUN_EN defined: add output rx_overrun (1-bit, sticky) set when a word completes while the previous rx_valid pulse is unacknowledged by input rx_ack; rx_ack high clears it. Reset value: 0.
REQ-027 Without SPI_SLAVE_OVERRUN_EN: no rx_ack/rx_overrun ports; rx_data is silently overwritten.

Structure
REQ-028 SHALL place the FSM state enum, DATA_W default and IDLE_WORD default in shared package spi_pkg, which the SPI master also uses.
REQ-029 SHALL place the synchroniser in sub-module spi_sync (parameter WIDTH, 2 stages, reset value vector); the slave instantiates it once for 3 bits.

Verification
REQ-030 Single word: tx 0xA5 loaded, master sends 0x3C at clk/10 -> miso returns 0xA5, rx_data=0x3C, one rx_valid pulse.
REQ-031 Nothing loaded: master sends 0x00 -> miso returns 0xFF, rx_valid once, tx_ready stays 1.
REQ-032 Back-to-back: tx 0x11 then 0x22 loaded during the first word, master sends 0x81,0x42 under one ss_n low -> miso 0x11,0x22; two rx_valid pulses carrying 0x81 then 0x42.
REQ-033 Abort: ss_n rises after 5 bits -> no rx_valid, rx_data unchanged; the next full transfer completes correctly.
REQ-034 Reset mid-word: rst low for 1 clk after bit 3 -> all outputs at reset values; next transfer correct.
REQ-035 With SPI_SLAVE_OVERRUN_EN defined: two words with no rx_ack -> rx_overrun=1 after the second; rx_ack clears it.
